cube_frame_decoder: RTL and testbench
=====================================

# cube_frame_decoder

Passive monitor that sits on the pixel-plot bus between the cube renderer and the VGA adapter and decodes the plotted stream back into the 54 sticker colour IDs of the cube. It tracks the renderer's fixed raster order, checks that every 8x8 sticker is a single valid colour, and publishes a validated cube state once per complete frame. It is used for on-chip self-check of the drawing path and as a bench scoreboard.

## Interface
- No parameters; the geometry is fixed by the cube net layout.
- clk  in  1  system clock
- resetn  in  1  reset; asynchronous, active-low
- x  in  8  plotted pixel x
- y  in  7  plotted pixel y
- colour  in  3  plotted RGB colour
- plot  in  1  pixel valid; sampled every rising clk edge
- cube_state  out  162  decoded state; sticker s (0..8) of face f (1..6) at [3*(9*(f-1)+s) +: 3]; f1 front, f2 back, f3 left, f4 right, f5 top, f6 bottom
- frame_valid  out  1  one-cycle pulse: cube_state just updated from a clean frame
- frame_bad  out  1  one-cycle pulse: a complete frame ended with a colour error; cube_state unchanged
- sync_err  out  1  one-cycle pulse: a plotted pixel did not match the expected position
- locked  out  1  high while in TRACK
- frame_count  out  8  count of clean frames; wraps 255 -> 0

## Operation
- Stream order: pixel index k = 0..3455; sticker n = k[12:6] (0..53); local pixel p = k[5:0], lx = p[2:0], ly = p[5:3].
- Display face d = n/9 (0 U, 1 L, 2 F, 3 R, 4 B, 5 D); si = n - 9d; col = si mod 3; row = si/3.
- Face bases (x,y): U (24,0), L (0,24), F (24,24), R (48,24), B (72,24), D (24,48).
- Expected position: x = base_x + 8*col + lx; y = base_y + 8*row + ly.
- Storage mapping: U->f5, L->f3, F->f1, R->f4, B->f2, D->f6.
- Colour decode: 111->0, 110->1, 001->2, 010->3, 100->4, 101->5. Codes 000 and 011 are invalid.
- Cycles with plot=0 are ignored in every state; gaps of any length are allowed.
- HUNT: if plot and (x,y)=(24,0), process the pixel as k=0, set k=1, go to TRACK. Otherwise stay in HUNT.
- TRACK, plot with (x,y) equal to the expected position for k: process the pixel and advance k.
- TRACK, plot with any other position:
  - pulse sync_err;
  - discard the shadow state and clear err;
  - if (x,y)=(24,0), restart at k=0 (process the pixel, stay in TRACK); otherwise go to HUNT.
- Process pixel:
  - invalid colour sets err;
  - if p=0, write shadow[n] = id;
  - otherwise, if id != shadow[n], set err.
  - err is sticky within a frame and is cleared at frame start.
- Frame end: the pixel at k=3455 is processed with the final err, which includes that pixel's own check.
  - err=0: cube_state <= shadow, including sticker 53 from this cycle; pulse frame_valid; frame_count+1.
  - err=1: pulse frame_bad.
  - In both cases k -> 0 and the block stays in TRACK.

## Timing
- All outputs are registered.
- Reset values: cube_state all 0, frame_valid 0, frame_bad 0, sync_err 0, locked 0, frame_count 0. The FSM resets to HUNT with k=0 and err=0.
- frame_valid/frame_bad assert, and cube_state updates, in the cycle after the edge that samples pixel 3455 (1-cycle latency).
- sync_err asserts in the cycle after the offending pixel is sampled. locked falls in the same cycle when the FSM goes to HUNT.
- locked rises in the cycle after (24,0) is sampled in HUNT.
- Back-to-back frames are supported: pixel 0 of the next frame may arrive in the cycle immediately after pixel 3455.
- Reset asserted mid-frame: all outputs and the FSM return to reset values immediately. Partial shadow contents are never published.

## Test plan
- Reset, then one gap-free frame of a solved cube (f1=2, f2=3, f3=5, f4=4, f5=0, f6=1 on all stickers) -> frame_valid pulses once, 1 cycle after pixel 3455; cube_state matches; frame_count=1; locked=1.
- Same frame with random plot=0 gaps (up to 5 cycles) -> identical result. A second frame sent back-to-back -> frame_count=2.
- Pixel p=5 of sticker n=10 driven as 001 instead of the sticker colour -> frame_bad pulses at frame end; cube_state and frame_count unchanged. The next clean frame -> frame_valid.
- Pixel k=100 omitted -> sync_err pulses once; locked=0 and no frame pulse for that frame. The next frame start relocks and yields frame_valid.
- Pixel 0 of sticker 0 driven with colour 011 -> frame_bad. Stray pixel (24,0) at k=2000 -> sync_err and immediate restart at k=0, with locked held at 1.
- resetn pulsed low at k=1500 -> all outputs 0 asynchronously. A following full frame -> frame_valid with frame_count=1.

Source files
------------

// File: rtl/cube_frame_decoder.sv
// Passive pixel-bus monitor: follows the cube renderer's raster order, rebuilds
// the 54 sticker colour IDs, and publishes them once per clean frame.
module cube_frame_decoder (
  input  logic         clk,
  input  logic         resetn,
  input  logic [7:0]   x,
  input  logic [6:0]   y,
  input  logic [2:0]   colour,
  input  logic         plot,
  output logic [161:0] cube_state,
  output logic         frame_valid,
  output logic         frame_bad,
  output logic         sync_err,
  output logic         locked,
  output logic [7:0]   frame_count
);
  localparam int unsigned KW = 12;
  localparam int unsigned SW = 162;
  localparam int unsigned FCW = 8;
  localparam logic [KW-1:0] LAST_K = KW'(3455);

  typedef enum logic {HUNT, TRACK} state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic            err_q, err_d;
  logic [SW-1:0]   shadow_q, shadow_d;
  logic [SW-1:0]   cube_state_q, cube_state_d;
  logic            frame_valid_q, frame_valid_d;
  logic            frame_bad_q, frame_bad_d;
  logic            sync_err_q, sync_err_d;
  logic            locked_q, locked_d;
  logic [FCW-1:0]  frame_count_q, frame_count_d;

  logic            at_origin;
  logic            do_proc;
  logic [KW-1:0]   proc_k;
  logic [14:0]     exp_xy;
  logic [7:0]      lsb;
  logic [3:0]      dec;
  logic            err_new;

  // Display face (U,L,F,R,B,D = 0..5) of sticker n in stream order.
  function automatic logic [2:0] disp_face(input logic [5:0] n);
    if (n >= 6'd45)      return 3'd5;
    else if (n >= 6'd36) return 3'd4;
    else if (n >= 6'd27) return 3'd3;
    else if (n >= 6'd18) return 3'd2;
    else if (n >= 6'd9)  return 3'd1;
    else                 return 3'd0;
  endfunction

  function automatic logic [3:0] face_idx(input logic [5:0] n, input logic [2:0] d);
    return 4'(n - 6'd9 * 6'(d));
  endfunction

  // Screen position {x, y} the renderer plots for stream index k.
  function automatic logic [14:0] exp_pos(input logic [KW-1:0] k);
    logic [2:0] d;
    logic [3:0] si;
    logic [7:0] bx;
    logic [6:0] by;
    logic [7:0] ex;
    logic [6:0] ey;
    d  = disp_face(k[11:6]);
    si = face_idx(k[11:6], d);
    case (d)
      3'd0:    begin bx = 8'd24; by = 7'd0;  end
      3'd1:    begin bx = 8'd0;  by = 7'd24; end
      3'd2:    begin bx = 8'd24; by = 7'd24; end
      3'd3:    begin bx = 8'd48; by = 7'd24; end
      3'd4:    begin bx = 8'd72; by = 7'd24; end
      default: begin bx = 8'd24; by = 7'd48; end
    endcase
    ex = bx + (8'(si % 4'd3) << 3) + 8'(k[2:0]);
    ey = by + (7'(si / 4'd3) << 3) + 7'(k[5:3]);
    return {ex, ey};
  endfunction

  // LSB of the sticker's field in storage order (f1 front .. f6 bottom).
  function automatic logic [7:0] slot_lsb(input logic [KW-1:0] k);
    logic [2:0] d;
    logic [3:0] si;
    logic [2:0] sf;
    logic [5:0] slot;
    d  = disp_face(k[11:6]);
    si = face_idx(k[11:6], d);
    case (d)
      3'd0:    sf = 3'd4;
      3'd1:    sf = 3'd2;
      3'd2:    sf = 3'd0;
      3'd3:    sf = 3'd3;
      3'd4:    sf = 3'd1;
      default: sf = 3'd5;
    endcase
    slot = 6'(6'd9 * 6'(sf) + 6'(si));
    return 8'd3 * 8'(slot);
  endfunction

  // Returns {valid, id}.
  function automatic logic [3:0] decode(input logic [2:0] c);
    case (c)
      3'b111:  return {1'b1, 3'd0};
      3'b110:  return {1'b1, 3'd1};
      3'b001:  return {1'b1, 3'd2};
      3'b010:  return {1'b1, 3'd3};
      3'b100:  return {1'b1, 3'd4};
      3'b101:  return {1'b1, 3'd5};
      default: return 4'b0000;
    endcase
  endfunction

  // Next-state, pixel processing and output logic.
  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    err_d         = err_q;
    shadow_d      = shadow_q;
    cube_state_d  = cube_state_q;
    frame_count_d = frame_count_q;
    frame_valid_d = 1'b0;
    frame_bad_d   = 1'b0;
    sync_err_d    = 1'b0;
    do_proc       = 1'b0;
    proc_k        = k_q;
    err_new       = 1'b0;
    at_origin     = (x == 8'd24) && (y == 7'd0);
    exp_xy        = exp_pos(k_q);

    if (plot) begin
      if (state_q == HUNT) begin
        if (at_origin) begin
          do_proc = 1'b1;
          proc_k  = '0;
          state_d = TRACK;
        end
      end else if ({x, y} == exp_xy) begin
        do_proc = 1'b1;
      end else begin
        sync_err_d = 1'b1;
        err_d      = 1'b0;
        k_d        = '0;
        if (at_origin) begin
          do_proc = 1'b1;
          proc_k  = '0;
        end else begin
          state_d = HUNT;
        end
      end
    end

    lsb = slot_lsb(proc_k);
    dec = decode(colour);

    if (do_proc) begin
      // Frame start (k=0) clears the sticky error.
      err_new = (proc_k == '0) ? 1'b0 : err_q;
      if (!dec[3]) err_new = 1'b1;
      if (proc_k[5:0] == 6'd0) shadow_d[lsb +: 3] = dec[2:0];
      else if (dec[2:0] != shadow_q[lsb +: 3]) err_new = 1'b1;
      err_d = err_new;
      if (proc_k == LAST_K) begin
        k_d = '0;
        if (!err_new) begin
          cube_state_d  = shadow_d;
          frame_valid_d = 1'b1;
          frame_count_d = frame_count_q + FCW'(1);
        end else begin
          frame_bad_d = 1'b1;
        end
      end else begin
        k_d = proc_k + KW'(1);
      end
    end

    locked_d = (state_d == TRACK);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= HUNT;
      k_q           <= '0;
      err_q         <= 1'b0;
      shadow_q      <= '0;
      cube_state_q  <= '0;
      frame_valid_q <= 1'b0;
      frame_bad_q   <= 1'b0;
      sync_err_q    <= 1'b0;
      locked_q      <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      err_q         <= err_d;
      shadow_q      <= shadow_d;
      cube_state_q  <= cube_state_d;
      frame_valid_q <= frame_valid_d;
      frame_bad_q   <= frame_bad_d;
      sync_err_q    <= sync_err_d;
      locked_q      <= locked_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign cube_state  = cube_state_q;
  assign frame_valid = frame_valid_q;
  assign frame_bad   = frame_bad_q;
  assign sync_err    = sync_err_q;
  assign locked      = locked_q;
  assign frame_count = frame_count_q;
endmodule

// File: tb/tb_cube_frame_decoder.sv
// Directed bench for cube_frame_decoder: integer reference model checked every
// cycle, plus literal expectations per scenario.
module tb_cube_frame_decoder;
  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [7:0]   x = '0;
  logic [6:0]   y = '0;
  logic [2:0]   colour = '0;
  logic         plot = 1'b0;
  logic [161:0] cube_state;
  logic         frame_valid, frame_bad, sync_err, locked;
  logic [7:0]   frame_count;

  int total = 0;
  int bad = 0;
  int n_fv = 0, n_fb = 0, n_se = 0;

  // Reference model state (values the DUT outputs should hold after the last edge).
  int m_track = 0, m_k = 0, m_err = 0, m_fc = 0;
  int m_fv = 0, m_fb = 0, m_se = 0;
  int m_shadow[1:6][0:8];
  int m_cube[1:6][0:8];

  int bx_t[6] = '{24, 0, 24, 48, 72, 24};
  int by_t[6] = '{0, 24, 24, 24, 24, 48};
  int sf_t[6] = '{5, 3, 1, 4, 2, 6};
  logic [2:0] code_t[6] = '{3'b111, 3'b101, 3'b001, 3'b100, 3'b010, 3'b110};
  int solved_id[1:6] = '{2, 3, 5, 4, 0, 1};

  always #5 clk = ~clk;

  cube_frame_decoder dut (
    .clk(clk), .resetn(resetn), .x(x), .y(y), .colour(colour), .plot(plot),
    .cube_state(cube_state), .frame_valid(frame_valid), .frame_bad(frame_bad),
    .sync_err(sync_err), .locked(locked), .frame_count(frame_count)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_vec(input string name, input logic [161:0] act, input logic [161:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void pos_of(input int k, output int ex, output int ey);
    int n, p, d, si;
    n = k / 64; p = k % 64; d = n / 9; si = n % 9;
    ex = bx_t[d] + 8 * (si % 3) + p % 8;
    ey = by_t[d] + 8 * (si / 3) + p / 8;
  endfunction

  function automatic int colour_id(input logic [2:0] c);
    case (c)
      3'b111: return 0;
      3'b110: return 1;
      3'b001: return 2;
      3'b010: return 3;
      3'b100: return 4;
      3'b101: return 5;
      default: return -1;
    endcase
  endfunction

  function automatic logic [161:0] cube_vec();
    logic [161:0] v;
    v = '0;
    for (int f = 1; f <= 6; f++)
      for (int s = 0; s < 9; s++)
        v[3 * (9 * (f - 1) + s) +: 3] = 3'(m_cube[f][s]);
    return v;
  endfunction

  function automatic logic [161:0] solved_vec();
    logic [161:0] v;
    v = '0;
    for (int f = 1; f <= 6; f++)
      for (int s = 0; s < 9; s++)
        v[3 * (9 * (f - 1) + s) +: 3] = 3'(solved_id[f]);
    return v;
  endfunction

  task automatic model_reset();
    m_track = 0; m_k = 0; m_err = 0; m_fc = 0;
    m_fv = 0; m_fb = 0; m_se = 0;
    for (int f = 1; f <= 6; f++)
      for (int s = 0; s < 9; s++) begin
        m_shadow[f][s] = 0;
        m_cube[f][s] = 0;
      end
  endtask

  task automatic model_proc(input int k);
    int n, p, d, si, f, id, e;
    n = k / 64; p = k % 64; d = n / 9; si = n % 9; f = sf_t[d];
    id = colour_id(colour);
    e = (k == 0) ? 0 : m_err;
    if (id < 0) e = 1;
    if (p == 0) m_shadow[f][si] = id;
    else if (id != m_shadow[f][si]) e = 1;
    m_err = e;
    m_track = 1;
    if (k == 3455) begin
      m_k = 0;
      if (e == 0) begin
        m_cube = m_shadow;
        m_fv = 1;
        m_fc = (m_fc + 1) % 256;
      end else m_fb = 1;
    end else m_k = k + 1;
  endtask

  // Advance the model by one clock edge using the inputs about to be sampled.
  task automatic model_step();
    int ex, ey;
    bit origin;
    m_fv = 0; m_fb = 0; m_se = 0;
    if (plot) begin
      origin = (int'(x) == 24) && (int'(y) == 0);
      if (m_track == 0) begin
        if (origin) model_proc(0);
      end else begin
        pos_of(m_k, ex, ey);
        if (int'(x) == ex && int'(y) == ey) model_proc(m_k);
        else begin
          m_se = 1;
          m_err = 0;
          if (origin) model_proc(0);
          else begin
            m_track = 0;
            m_k = 0;
          end
        end
      end
    end
  endtask

  // Compare DUT against model every cycle, then step the model.
  initial forever begin
    @(negedge clk);
    if (!resetn) model_reset();
    if (frame_valid) n_fv++;
    if (frame_bad) n_fb++;
    if (sync_err) n_se++;
    check("frame_valid", int'(frame_valid), m_fv);
    check("frame_bad", int'(frame_bad), m_fb);
    check("sync_err", int'(sync_err), m_se);
    check("locked", int'(locked), m_track);
    check("frame_count", int'(frame_count), m_fc);
    check_vec("cube_state", cube_state, cube_vec());
    if (resetn) model_step();
  end

  task automatic drive(input int px, input int py, input logic [2:0] c);
    x = 8'(px); y = 7'(py); colour = c; plot = 1'b1;
    @(posedge clk); #1;
    plot = 1'b0;
  endtask

  task automatic idle(input int n);
    plot = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input int k0, input int k1, input int gap_max,
                            input int bad_k, input logic [2:0] bad_c, input int skip_k);
    int ex, ey;
    logic [2:0] c;
    for (int k = k0; k <= k1; k++) begin
      if (k == skip_k) continue;
      pos_of(k, ex, ey);
      c = (k == bad_k) ? bad_c : code_t[(k / 64) / 9];
      drive(ex, ey, c);
      if (gap_max > 0 && $urandom_range(3, 0) == 0) idle(int'($urandom_range(gap_max, 1)));
    end
  endtask

  initial begin
    int ex, ey;
    resetn = 1'b0;
    idle(3);
    check("rst_locked", int'(locked), 0);
    check("rst_count", int'(frame_count), 0);
    check_vec("rst_cube", cube_state, '0);
    resetn = 1'b1;
    idle(2);

    // Pin the model's raster geometry.
    pos_of(0, ex, ey);    check("pos_k0_x", ex, 24);  check("pos_k0_y", ey, 0);
    pos_of(576, ex, ey);  check("pos_k576_x", ex, 0); check("pos_k576_y", ey, 24);
    pos_of(100, ex, ey);  check("pos_k100_x", ex, 36); check("pos_k100_y", ey, 4);
    pos_of(3455, ex, ey); check("pos_klast_x", ex, 47); check("pos_klast_y", ey, 71);

    // Clean gap-free frame; frame_valid visible right after pixel 3455's edge.
    send_frame(0, 3454, 0, -1, 3'b000, -1);
    check("pre_last_valid", int'(frame_valid), 0);
    drive(47, 71, 3'b110);
    check("f1_valid_now", int'(frame_valid), 1);
    check("f1_count_now", int'(frame_count), 1);
    idle(3);
    check("f1_pulses", n_fv, 1);
    check("f1_locked", int'(locked), 1);
    check_vec("f1_cube", cube_state, solved_vec());

    // Gapped frame then a back-to-back frame.
    send_frame(0, 3455, 5, -1, 3'b000, -1);
    send_frame(0, 3455, 0, -1, 3'b000, -1);
    idle(3);
    check("b2b_count", int'(frame_count), 3);
    check("b2b_pulses", n_fv, 3);

    // Wrong colour at sticker 10 pixel 5 (k=645).
    send_frame(0, 3455, 0, 645, 3'b001, -1);
    idle(3);
    check("badpix_fb", n_fb, 1);
    check("badpix_count", int'(frame_count), 3);
    check_vec("badpix_cube", cube_state, solved_vec());
    send_frame(0, 3455, 0, -1, 3'b000, -1);
    idle(3);
    check("recover1_count", int'(frame_count), 4);

    // Missing pixel k=100.
    send_frame(0, 3455, 0, -1, 3'b000, 100);
    idle(3);
    check("skip_se", n_se, 1);
    check("skip_locked", int'(locked), 0);
    check("skip_fv", n_fv, 4);
    check("skip_fb", n_fb, 1);
    send_frame(0, 3455, 0, -1, 3'b000, -1);
    idle(3);
    check("relock_count", int'(frame_count), 5);
    check("relock_locked", int'(locked), 1);

    // Invalid code 011 on the very first pixel.
    send_frame(0, 3455, 0, 0, 3'b011, -1);
    idle(3);
    check("inv_fb", n_fb, 2);
    check("inv_count", int'(frame_count), 5);

    // Stray (24,0) at k=2000 restarts the frame without losing lock.
    send_frame(0, 1999, 0, -1, 3'b000, -1);
    drive(24, 0, 3'b111);
    check("stray_se", int'(sync_err), 1);
    check("stray_locked", int'(locked), 1);
    send_frame(1, 3455, 0, -1, 3'b000, -1);
    idle(3);
    check("stray_se_total", n_se, 2);
    check("stray_count", int'(frame_count), 6);
    check("stray_fv", n_fv, 6);

    // Asynchronous reset mid-frame.
    send_frame(0, 1499, 0, -1, 3'b000, -1);
    resetn = 1'b0;
    #2;
    check("arst_locked", int'(locked), 0);
    check("arst_count", int'(frame_count), 0);
    check("arst_se", int'(sync_err), 0);
    check_vec("arst_cube", cube_state, '0);
    @(posedge clk); #1;
    resetn = 1'b1;
    idle(2);
    send_frame(0, 3455, 0, -1, 3'b000, -1);
    idle(3);
    check("post_rst_count", int'(frame_count), 1);
    check("post_rst_locked", int'(locked), 1);
    check_vec("post_rst_cube", cube_state, solved_vec());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
